ccip_txn_tracker: RTL and testbench
===================================

# ccip_txn_tracker

Parametrised, synthesizable successor to the CCI-P transaction logger. It does more than print valid strobes: it tracks every outstanding request tag on each request channel and flags protocol errors in hardware. The flagged errors are duplicate-tag requests, orphan responses and response timeouts. Each error is timestamped and queued in a ready/valid event FIFO. The block sits beside the AFU on the CCI-P boundary, snooping requests and responses, and drives no CCI-P signal.

## Interface
- `NUM_CHAN`, 2 — tracked request/response channel pairs (ch0 = C0 read, ch1 = C1 write).
- `MDATA_WIDTH`, 16 — mdata field width.
- `TAG_BITS`, 6 — low mdata bits used as tag; 2^TAG_BITS tags per channel.
- `TIMEOUT_CYCLES`, 4096 — max request-to-response age; must be < 2^31.
- `EVT_DEPTH`, 16 — event FIFO depth, power of two ≥ 2.

Ports:
- `clk` in 1 — clock.
- `SoftReset_n` in 1 — synchronous, active-low reset.
- `enable` in 1 — tracking enable. When 0, inputs are ignored and state holds.
- `req_valid` in NUM_CHAN — request strobe per channel.
- `req_mdata` in NUM_CHAN×MDATA_WIDTH — request mdata.
- `rsp_valid` in NUM_CHAN — response strobe per channel.
- `rsp_mdata` in NUM_CHAN×MDATA_WIDTH — response mdata.
- `evt_valid` out 1 — event available.
- `evt_ready` in 1 — consumer accepts event.
- `evt_data` out evt_t — {code[1:0], chan, tag, time[31:0]}.
- `outstanding` out NUM_CHAN×(TAG_BITS+1) — live outstanding count per channel.
- `hiwater` out NUM_CHAN×(TAG_BITS+1) — peak outstanding count since reset.
- `evt_drop_cnt` out 16 — events lost; saturating.
- `err_sticky` out 1 — any error since reset.

## Operation
- Per channel: a valid bitmap `pend[2^TAG_BITS]` and a 32-bit issue stamp per tag. The global 32-bit cycle counter `now` increments every cycle, regardless of `enable`, and wraps.
- Request on tag t:
  - `pend[t]` = 0: set it, store `now`.
  - `pend[t]` = 1: raise DUP_REQ, re-stamp, `pend` stays 1.
- Response on tag t:
  - `pend[t]` = 1: clear it.
  - `pend[t]` = 0: raise ORPHAN_RSP, no state change.
- Timeout scanner: one per channel, a TAG_BITS index advancing by 1 per enabled cycle and wrapping at 2^TAG_BITS−1. Age is `(now − stamp)` mod 2^32. If `pend[idx]` and age ≥ TIMEOUT_CYCLES: raise TIMEOUT, clear `pend[idx]`.
- Same channel, same tag, same cycle:
  - Response is applied first, then the request; so rsp+req on an outstanding tag is legal and leaves it pending with a new stamp.
  - A scanner hit on a tag touched by req or rsp that cycle is suppressed.
- `outstanding` = population of `pend`. It updates by +1/−1/0 per cycle. It never exceeds 2^TAG_BITS and never underflows. `hiwater` = running max.
- Event sources per cycle: 3×NUM_CHAN.
  - Priority order: lower channel first; within a channel ORPHAN_RSP > DUP_REQ > TIMEOUT.
  - At most one event is pushed per cycle. Every other raised event increments `evt_drop_cnt`.
  - A push while the FIFO is full (and not popping this cycle) is also dropped and counted.
  - `evt_drop_cnt` saturates at 0xFFFF.
- Event codes: 0 reserved, 1 DUP_REQ, 2 ORPHAN_RSP, 3 TIMEOUT. The time field = `now` of the detecting cycle.
- `err_sticky` sets on any raised event, pushed or dropped.

## Timing
- Reset: all `pend` cleared, scanners = 0, `now` = 0, FIFO empty.
- Outputs during reset: `evt_valid` 0, `evt_data` 0, `outstanding` 0, `hiwater` 0, `evt_drop_cnt` 0, `err_sticky` 0.
- Reset mid-operation discards all pending tags and queued events, and raises no events.
- `outstanding`/`hiwater` reflect cycle N inputs at cycle N+1.
- An event detected in cycle N with the FIFO empty gives `evt_valid` = 1 at N+1. The FIFO is show-ahead; a pop occurs on `evt_valid && evt_ready`.
- Simultaneous push and pop on a full FIFO succeeds: no drop.
- Timeout detection latency: between TIMEOUT_CYCLES and TIMEOUT_CYCLES + 2^TAG_BITS cycles after issue, with `enable` held high.
- `enable` = 0 freezes scanners, `pend`, and event generation. The FIFO still drains.

## Structure
- Package `ccip_trk_pkg`: `evt_code_e` enum, `evt_t` packed struct, `TS_WIDTH` = 32.
- Sub-module `ccip_trk_evt_fifo`: parametrised synchronous show-ahead FIFO of `evt_t`, with a full/empty flag and a `push_drop` pulse.
- Per-channel tag bitmap, stamp RAM and scanner are in a generate loop in the top module.

## Test plan
- Ch0 request tag 5 at cycle 10, response tag 5 at cycle 20 → `outstanding[0]` goes 0→1 at 11 and 1→0 at 21; no event; `err_sticky` 0.
- Ch1 request tag 3 twice, 4 cycles apart → one DUP_REQ event {code 1, chan 1, tag 3, time = second-request cycle}; `outstanding[1]` = 1.
- Ch0 response tag 9 with nothing pending → ORPHAN_RSP {2, 0, 9} visible one cycle later; `err_sticky` = 1.
- TIMEOUT_CYCLES = 100, TAG_BITS = 2: ch0 request tag 1, no response → TIMEOUT within cycles 100–104 after issue; `outstanding[0]` returns to 0.
- EVT_DEPTH = 4, `evt_ready` = 0: generate 6 orphan responses, then add 2 same-cycle orphans on ch0+ch1 → FIFO holds 4 events, `evt_drop_cnt` = 4 (2 overflow drops plus 2 later full-FIFO drops counted per event; check against total raised − 4).
- Fill all 64 ch0 tags, assert `SoftReset_n` = 0 for 1 cycle → `outstanding` 0, `hiwater` 0, `evt_valid` 0 next cycle; a subsequent response raises ORPHAN_RSP.

Source files
------------

// File: rtl/ccip_txn_tracker_pkg.sv
// Shared types for the CCI-P transaction tracker: event codes, the queued event record
// and a helper that assembles one.
package ccip_trk_pkg;

  localparam int TS_WIDTH   = 32;
  localparam int EVT_CHAN_W = 4;  // channel field holds up to 16 channels
  localparam int EVT_TAG_W  = 8;  // tag field holds TAG_BITS up to 8

  typedef enum logic [1:0] {
    EVT_RSVD       = 2'd0,
    EVT_DUP_REQ    = 2'd1,
    EVT_ORPHAN_RSP = 2'd2,
    EVT_TIMEOUT    = 2'd3
  } evt_code_e;

  typedef struct packed {
    evt_code_e               code;
    logic [EVT_CHAN_W-1:0]   chan;
    logic [EVT_TAG_W-1:0]    tag;
    logic [TS_WIDTH-1:0]     ts;
  } evt_t;

  function automatic evt_t mkEvt(evt_code_e code, logic [EVT_CHAN_W-1:0] chan,
                                 logic [EVT_TAG_W-1:0] tag, logic [TS_WIDTH-1:0] ts);
    evt_t e;
    e.code = code;
    e.chan = chan;
    e.tag  = tag;
    e.ts   = ts;
    return e;
  endfunction

endpackage

// File: rtl/ccip_txn_tracker_if.sv
// Snoop-side bundle for the CCI-P transaction tracker: request/response strobes in,
// event stream and per-channel counters out.
interface ccip_txn_tracker_if #(
  parameter int NUM_CHAN    = 2,
  parameter int MDATA_WIDTH = 16,
  parameter int TAG_BITS    = 6
);
  import ccip_trk_pkg::*;

  logic [NUM_CHAN-1:0]                  req_valid;
  logic [NUM_CHAN-1:0][MDATA_WIDTH-1:0] req_mdata;
  logic [NUM_CHAN-1:0]                  rsp_valid;
  logic [NUM_CHAN-1:0][MDATA_WIDTH-1:0] rsp_mdata;
  logic                                 evt_valid;
  logic                                 evt_ready;
  evt_t                                 evt_data;
  logic [NUM_CHAN-1:0][TAG_BITS:0]      outstanding;
  logic [NUM_CHAN-1:0][TAG_BITS:0]      hiwater;
  logic [15:0]                          evt_drop_cnt;
  logic                                 err_sticky;

  modport master (
    output req_valid, req_mdata, rsp_valid, rsp_mdata, evt_ready,
    input  evt_valid, evt_data, outstanding, hiwater, evt_drop_cnt, err_sticky
  );

  modport slave (
    input  req_valid, req_mdata, rsp_valid, rsp_mdata, evt_ready,
    output evt_valid, evt_data, outstanding, hiwater, evt_drop_cnt, err_sticky
  );

endinterface

// File: rtl/ccip_txn_tracker_evt_fifo.sv
// Show-ahead event FIFO; pushDrop pulses when a push is refused because the FIFO is full
// and the head is not leaving in the same cycle.
module ccip_trk_evt_fifo
  import ccip_trk_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic SoftReset_n,
  input  logic pushValid,
  input  evt_t pushData,
  output logic pushDrop,
  output logic full,
  output logic empty,
  output logic popValid,
  input  logic popReady,
  output evt_t popData
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wrPtr, rdPtr;
  evt_t        mem [DEPTH];
  logic        doPush, doPop;

  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop    = !empty && popReady;
  assign doPush   = pushValid && (!full || doPop);
  assign pushDrop = pushValid && !doPush;
  assign popValid = !empty;
  assign popData  = empty ? '0 : mem[rdPtr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // NOTE: storage carries no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/ccip_txn_tracker.sv
// CCI-P transaction tracker: per-channel tag bookkeeping with duplicate, orphan and timeout
// detection feeding a timestamped event FIFO. Pure snooper; drives no CCI-P signal.
module ccip_txn_tracker
  import ccip_trk_pkg::*;
#(
  parameter int NUM_CHAN       = 2,
  parameter int MDATA_WIDTH    = 16,
  parameter int TAG_BITS       = 6,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int EVT_DEPTH      = 16
) (
  input  logic clk,
  input  logic SoftReset_n,
  input  logic enable,
  ccip_txn_tracker_if.slave bus
);
  localparam int NTAG = 1 << TAG_BITS;
  localparam int CW   = TAG_BITS + 1;
  localparam logic [TS_WIDTH-1:0] TIMEOUT_TS = TS_WIDTH'(TIMEOUT_CYCLES);

  logic [TS_WIDTH-1:0]               nowReg;
  logic [NUM_CHAN-1:0]               orphanV, dupV, tmoV;
  logic [NUM_CHAN-1:0][TAG_BITS-1:0] orphanTag, dupTag, tmoTag;
  logic [NUM_CHAN-1:0][CW-1:0]       cntArr, hiwArr;
  logic [NUM_CHAN-1:0][MDATA_WIDTH-1:0] unusedMdata;

  assign unusedMdata = bus.req_mdata ^ bus.rsp_mdata;

  for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
    logic [NTAG-1:0]     pend, pendNext;
    logic [TS_WIDTH-1:0] stamp [NTAG];
    logic [TAG_BITS-1:0] scanIdx, reqTag, rspTag;
    logic [CW-1:0]       cnt, cntNext, hiw;
    logic [TS_WIDTH-1:0] age;
    logic reqHit, rspHit, rspClr, reqBusy, reqSet, touched, tmo;

    assign reqTag  = bus.req_mdata[c][TAG_BITS-1:0];
    assign rspTag  = bus.rsp_mdata[c][TAG_BITS-1:0];
    assign reqHit  = enable && bus.req_valid[c];
    assign rspHit  = enable && bus.rsp_valid[c];
    assign rspClr  = rspHit && pend[rspTag];
    // The response lands first, so a request only collides with a tag it leaves pending
    assign reqBusy = pend[reqTag] && !(rspHit && (rspTag == reqTag));
    assign reqSet  = reqHit && !reqBusy;
    assign touched = (rspHit && (rspTag == scanIdx)) || (reqHit && (reqTag == scanIdx));
    assign age     = nowReg - stamp[scanIdx];
    assign tmo     = enable && pend[scanIdx] && !touched && (age >= TIMEOUT_TS);
    assign cntNext = cnt + CW'(reqSet) - CW'(rspClr) - CW'(tmo);

    // NOTE: the default is assigned first so no path through this block infers a latch.
    always_comb begin
      pendNext = pend;
      if (rspHit) pendNext[rspTag]  = 1'b0;
      if (reqHit) pendNext[reqTag]  = 1'b1;
      if (tmo)    pendNext[scanIdx] = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (!SoftReset_n) begin
        pend    <= '0;
        scanIdx <= '0;
        cnt     <= '0;
        hiw     <= '0;
      end else begin
        pend <= pendNext;
        cnt  <= cntNext;
        if (cntNext > hiw) hiw <= cntNext;
        if (enable) scanIdx <= scanIdx + TAG_BITS'(1);
      end
    end

    // Duplicates re-stamp as well, so the age restarts from the latest issue
    always_ff @(posedge clk) begin
      if (reqHit) stamp[reqTag] <= nowReg;
    end

    assign orphanV[c]   = rspHit && !pend[rspTag];
    assign orphanTag[c] = rspTag;
    assign dupV[c]      = reqHit && reqBusy;
    assign dupTag[c]    = reqTag;
    assign tmoV[c]      = tmo;
    assign tmoTag[c]    = scanIdx;
    assign cntArr[c]    = cnt;
    assign hiwArr[c]    = hiw;
  end

  evt_t        pushEvt;
  logic        pushValid, pushDrop, unusedFifoFull, unusedFifoEmpty;
  logic [7:0]  raisedCnt, dropInc;
  logic [16:0] dropSum;
  logic [15:0] dropCnt;
  logic        errSticky;

  // NOTE: blocking assignments here; the loop accumulates in order within one evaluation.
  always_comb begin
    pushValid = 1'b0;
    pushEvt   = '0;
    raisedCnt = '0;
    // Lower channel first; within a channel orphan, then duplicate, then timeout
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (orphanV[c]) begin
        raisedCnt = raisedCnt + 8'd1;
        if (!pushValid) begin
          pushValid = 1'b1;
          pushEvt   = mkEvt(EVT_ORPHAN_RSP, EVT_CHAN_W'(c), EVT_TAG_W'(orphanTag[c]), nowReg);
        end
      end
      if (dupV[c]) begin
        raisedCnt = raisedCnt + 8'd1;
        if (!pushValid) begin
          pushValid = 1'b1;
          pushEvt   = mkEvt(EVT_DUP_REQ, EVT_CHAN_W'(c), EVT_TAG_W'(dupTag[c]), nowReg);
        end
      end
      if (tmoV[c]) begin
        raisedCnt = raisedCnt + 8'd1;
        if (!pushValid) begin
          pushValid = 1'b1;
          pushEvt   = mkEvt(EVT_TIMEOUT, EVT_CHAN_W'(c), EVT_TAG_W'(tmoTag[c]), nowReg);
        end
      end
    end
  end

  assign dropInc = raisedCnt - {7'd0, pushValid} + {7'd0, pushDrop};
  assign dropSum = {1'b0, dropCnt} + {9'd0, dropInc};

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      nowReg    <= '0;
      dropCnt   <= '0;
      errSticky <= 1'b0;
    end else begin
      nowReg  <= nowReg + TS_WIDTH'(1);
      dropCnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      if (raisedCnt != 8'd0) errSticky <= 1'b1;
    end
  end

  ccip_trk_evt_fifo #(.DEPTH(EVT_DEPTH)) u_evt_fifo (
    .clk        (clk),
    .SoftReset_n(SoftReset_n),
    .pushValid  (pushValid),
    .pushData   (pushEvt),
    .pushDrop   (pushDrop),
    .full       (unusedFifoFull),
    .empty      (unusedFifoEmpty),
    .popValid   (bus.evt_valid),
    .popReady   (bus.evt_ready),
    .popData    (bus.evt_data)
  );

  assign bus.outstanding  = cntArr;
  assign bus.hiwater      = hiwArr;
  assign bus.evt_drop_cnt = dropCnt;
  assign bus.err_sticky   = errSticky;

endmodule

// File: tb/tb_ccip_txn_tracker.sv
// Directed bench for ccip_txn_tracker: a tag/queue model derived from the tracking rules is
// compared every cycle, and literal expectations pin the main scenarios.
module tb_ccip_txn_tracker;
  import ccip_trk_pkg::*;

  localparam int NUM_CHAN       = 2;
  localparam int MDATA_WIDTH    = 16;
  localparam int TAG_BITS       = 6;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int EVT_DEPTH      = 4;
  localparam int NTAG           = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  ccip_txn_tracker_if #(.NUM_CHAN(NUM_CHAN), .MDATA_WIDTH(MDATA_WIDTH), .TAG_BITS(TAG_BITS)) bus ();

  ccip_txn_tracker #(
    .NUM_CHAN(NUM_CHAN), .MDATA_WIDTH(MDATA_WIDTH), .TAG_BITS(TAG_BITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .EVT_DEPTH(EVT_DEPTH)
  ) dut (
    .clk(clk), .SoftReset_n(rst_n), .enable(enable), .bus(bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic evt_t mkE(input int code, input int c, input int t, input logic [31:0] ts);
    evt_t e;
    e.code = evt_code_e'(code);
    e.chan = 4'(c);
    e.tag  = 8'(t);
    e.ts   = ts;
    return e;
  endfunction

  // Reference model: tag sets per channel, issue times, a scan pointer and an event queue
  bit          mPend  [NUM_CHAN][NTAG];
  logic [31:0] mStamp [NUM_CHAN][NTAG];
  int          mScan  [NUM_CHAN];
  int          mOut   [NUM_CHAN];
  int          mHi    [NUM_CHAN];
  logic [31:0] mNow;
  evt_t        mQ[$];
  int          mDrop;
  bit          mSticky;
  int          tbCyc;

  task automatic modelStep();
    evt_t raised[$];
    bit   doPop, rv, qv, touched;
    int   rt, qt, si;
    if (!rst_n) begin
      foreach (mPend[c, t]) mPend[c][t] = 1'b0;
      foreach (mScan[c]) begin
        mScan[c] = 0; mOut[c] = 0; mHi[c] = 0;
      end
      mNow = '0; mQ.delete(); mDrop = 0; mSticky = 1'b0;
      return;
    end
    doPop = (mQ.size() > 0) && bus.evt_ready;
    if (enable) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        rv = bus.rsp_valid[c];
        qv = bus.req_valid[c];
        rt = int'(bus.rsp_mdata[c][TAG_BITS-1:0]);
        qt = int'(bus.req_mdata[c][TAG_BITS-1:0]);
        si = mScan[c];
        touched = (rv && rt == si) || (qv && qt == si);
        if (rv) begin
          if (mPend[c][rt]) mPend[c][rt] = 1'b0;
          else raised.push_back(mkE(2, c, rt, mNow));
        end
        if (qv) begin
          if (mPend[c][qt]) raised.push_back(mkE(1, c, qt, mNow));
          mPend[c][qt] = 1'b1;
          mStamp[c][qt] = mNow;
        end
        if (!touched && mPend[c][si] && (32'(mNow - mStamp[c][si]) >= 32'(TIMEOUT_CYCLES))) begin
          raised.push_back(mkE(3, c, si, mNow));
          mPend[c][si] = 1'b0;
        end
        mScan[c] = (si + 1) % NTAG;
      end
    end
    if (doPop) void'(mQ.pop_front());
    if (raised.size() > 0) begin
      mSticky = 1'b1;
      if (mQ.size() < EVT_DEPTH) mQ.push_back(raised[0]);
      else mDrop++;
      mDrop += raised.size() - 1;
      if (mDrop > 65535) mDrop = 65535;
    end
    for (int c = 0; c < NUM_CHAN; c++) begin
      mOut[c] = 0;
      for (int t = 0; t < NTAG; t++) mOut[c] += int'(mPend[c][t]);
      if (mOut[c] > mHi[c]) mHi[c] = mOut[c];
    end
    mNow = mNow + 32'd1;
  endtask

  task automatic compareAll();
    evt_t expData;
    expData = '0;
    if (mQ.size() > 0) expData = mQ[0];
    check("model_evt_valid", 64'(bus.evt_valid), 64'(mQ.size() > 0));
    check("model_evt_data", 64'(bus.evt_data), 64'(expData));
    for (int c = 0; c < NUM_CHAN; c++) begin
      check("model_outstanding", 64'(bus.outstanding[c]), 64'(mOut[c]));
      check("model_hiwater", 64'(bus.hiwater[c]), 64'(mHi[c]));
    end
    check("model_drop_cnt", 64'(bus.evt_drop_cnt), 64'(mDrop));
    check("model_err_sticky", 64'(bus.err_sticky), 64'(mSticky));
  endtask

  initial begin
    tbCyc = 0;
    forever begin
      @(posedge clk);
      modelStep();
      if (!rst_n) tbCyc = 0;
      else tbCyc++;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      compareAll();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; 'when' is the cycle count (DUT time) at which it is sampled
  task automatic pulse(input bit isRsp, input int c, input int t, output int when);
    when = tbCyc;
    if (isRsp) begin
      bus.rsp_valid[c] = 1'b1;
      bus.rsp_mdata[c] = 16'hA500 | 16'(t);
    end else begin
      bus.req_valid[c] = 1'b1;
      bus.req_mdata[c] = 16'hA500 | 16'(t);
    end
    tick();
    bus.rsp_valid = '0;
    bus.req_valid = '0;
  endtask

  int   w1, w2, w, lat;
  bit   found;
  evt_t ev;
  logic [6:0] outAtHit;

  initial begin
    rst_n = 1'b0; enable = 1'b1;
    bus.req_valid = '0; bus.rsp_valid = '0;
    bus.req_mdata = '0; bus.rsp_mdata = '0;
    bus.evt_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_evt_valid", 64'(bus.evt_valid), 64'd0);
    check("rst_evt_data", 64'(bus.evt_data), 64'd0);
    check("rst_outstanding", 64'(bus.outstanding), 64'd0);
    check("rst_err_sticky", 64'(bus.err_sticky), 64'd0);
    tick();
    rst_n = 1'b1;

    // Request then response on ch0 tag 5
    repeat (5) tick();
    pulse(1'b0, 0, 5, w);
    @(negedge clk);
    check("req_outstanding_up", 64'(bus.outstanding[0]), 64'd1);
    repeat (9) tick();
    pulse(1'b1, 0, 5, w);
    @(negedge clk);
    check("rsp_outstanding_down", 64'(bus.outstanding[0]), 64'd0);
    check("clean_no_event", 64'(bus.evt_valid), 64'd0);
    check("clean_no_sticky", 64'(bus.err_sticky), 64'd0);

    // Duplicate request on ch1 tag 3, four cycles apart
    pulse(1'b0, 1, 3, w1);
    repeat (3) tick();
    pulse(1'b0, 1, 3, w2);
    @(negedge clk);
    check("dup_evt_valid", 64'(bus.evt_valid), 64'd1);
    check("dup_evt_data", 64'(bus.evt_data), 64'(mkE(1, 1, 3, 32'(w1 + 4))));
    check("dup_outstanding", 64'(bus.outstanding[1]), 64'd1);
    pulse(1'b1, 1, 3, w);

    // Orphan response on ch0 tag 9
    pulse(1'b1, 0, 9, w);
    @(negedge clk);
    check("orphan_evt_valid", 64'(bus.evt_valid), 64'd1);
    check("orphan_evt_data", 64'(bus.evt_data), 64'(mkE(2, 0, 9, 32'(w))));
    check("orphan_sticky", 64'(bus.err_sticky), 64'd1);

    // Timeout on ch0 tag 1
    pulse(1'b0, 0, 1, w);
    found = 1'b0;
    ev = '0;
    outAtHit = '0;
    for (int i = 0; i < 250 && !found; i++) begin
      @(negedge clk);
      if (bus.evt_valid) begin
        found = 1'b1;
        ev = bus.evt_data;
        outAtHit = bus.outstanding[0];
      end
    end
    lat = int'(ev.ts) - w;
    check("tmo_seen_within_bound", 64'(found), 64'd1);
    check("tmo_evt_header", 64'({ev.code, ev.chan, ev.tag}), 64'({2'd3, 4'd0, 8'd1}));
    check("tmo_latency_window", 64'(lat >= TIMEOUT_CYCLES && lat <= TIMEOUT_CYCLES + NTAG), 64'd1);
    check("tmo_outstanding_cleared", 64'(outAtHit), 64'd0);

    // Same-cycle response+request on a pending tag is legal; enable=0 freezes state
    pulse(1'b0, 0, 7, w);
    bus.rsp_valid[0] = 1'b1; bus.rsp_mdata[0] = 16'd7;
    bus.req_valid[0] = 1'b1; bus.req_mdata[0] = 16'd7;
    tick();
    bus.rsp_valid = '0; bus.req_valid = '0;
    @(negedge clk);
    check("rsp_req_same_no_event", 64'(bus.evt_valid), 64'd0);
    check("rsp_req_same_pending", 64'(bus.outstanding[0]), 64'd1);
    enable = 1'b0;
    pulse(1'b1, 0, 7, w);
    @(negedge clk);
    check("disabled_holds_pend", 64'(bus.outstanding[0]), 64'd1);
    enable = 1'b1;
    pulse(1'b1, 0, 7, w);
    @(negedge clk);
    check("enabled_rsp_clears", 64'(bus.outstanding[0]), 64'd0);

    // Overflow: six orphans into a depth-4 FIFO, then two same-cycle orphans
    bus.evt_ready = 1'b0;
    pulse(1'b1, 0, 10, w1);
    for (int i = 1; i < 6; i++) pulse(1'b1, 0, 10 + i, w);
    bus.rsp_valid = 2'b11;
    bus.rsp_mdata[0] = 16'd20;
    bus.rsp_mdata[1] = 16'd20;
    tick();
    bus.rsp_valid = '0;
    @(negedge clk);
    check("ovf_drop_cnt", 64'(bus.evt_drop_cnt), 64'd4);
    check("ovf_head", 64'(bus.evt_data), 64'(mkE(2, 0, 10, 32'(w1))));
    bus.evt_ready = 1'b1;
    pulse(1'b1, 1, 21, w);
    @(negedge clk);
    check("full_push_pop_no_drop", 64'(bus.evt_drop_cnt), 64'd4);
    check("full_push_pop_head", 64'(bus.evt_data), 64'(mkE(2, 0, 11, 32'(w1 + 1))));
    repeat (6) tick();
    @(negedge clk);
    check("drained_empty", 64'(bus.evt_valid), 64'd0);

    // Fill every ch0 tag, then a one-cycle reset
    for (int t = 0; t < NTAG; t++) pulse(1'b0, 0, t, w);
    @(negedge clk);
    check("fill_outstanding", 64'(bus.outstanding[0]), 64'd64);
    check("fill_hiwater", 64'(bus.hiwater[0]), 64'd64);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst2_outstanding", 64'(bus.outstanding), 64'd0);
    check("rst2_hiwater", 64'(bus.hiwater), 64'd0);
    check("rst2_evt_valid", 64'(bus.evt_valid), 64'd0);
    check("rst2_drop_cnt", 64'(bus.evt_drop_cnt), 64'd0);
    check("rst2_sticky", 64'(bus.err_sticky), 64'd0);
    pulse(1'b1, 0, 0, w);
    @(negedge clk);
    check("post_rst_orphan", 64'(bus.evt_data), 64'(mkE(2, 0, 0, 32'd0)));
    check("post_rst_orphan_valid", 64'(bus.evt_valid), 64'd1);

    repeat (3) tick();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
